// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR scheduler.
//   fir_state_t : controller state encoding
//   ADDR_SHIFT  : word index to BRAM byte address shift (32-bit words)
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_CALC    = 3'd3,
    ST_OUT     = 3'd4
  } fir_state_t;

  localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/fir_addr_gen.sv
// fir_addr_gen: index counters for the FIR scheduler.
// Ports:
//   aclk, areset      clock, async active-high reset
//   tap_num           latched tap count (ring depth of the current run)
//   run_clr           start of a run: clears every counter
//   k_clr / k_inc     clear / advance the per-step index (INIT word, CALC tap)
//   wptr_adv          advance the ring write pointer, wrapping at tap_num
//   smp_inc           count one completed, non-final result
//   k_idx             tap index (also the INIT word index)
//   data_idx          ring index of the sample that pairs with k_idx
//   wptr, smp_cnt     ring write pointer and completed-result count
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int TW = 6,
  parameter int DW = 11
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [TW-1:0] tap_num,
  input  logic          run_clr,
  input  logic          k_clr,
  input  logic          k_inc,
  input  logic          wptr_adv,
  input  logic          smp_inc,
  output logic [TW-1:0] k_idx,
  output logic [TW-1:0] data_idx,
  output logic [TW-1:0] wptr,
  output logic [DW-1:0] smp_cnt
);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      k_idx   <= '0;
      wptr    <= '0;
      smp_cnt <= '0;
    end else begin
      if (run_clr || k_clr)
        k_idx <= '0;
      else if (k_inc)
        k_idx <= k_idx + 1'b1;

      if (run_clr)
        wptr <= '0;
      else if (wptr_adv)
        wptr <= (wptr == tap_num - 1'b1) ? '0 : wptr + 1'b1;

      if (run_clr)
        smp_cnt <= '0;
      else if (smp_inc)
        smp_cnt <= smp_cnt + 1'b1;
    end
  end

  // (wptr - k) mod tap_num without a divider; wptr + tap_num never
  // overflows TW bits because both stay below 2*MAX_TAP_NUM.
  assign data_idx = (wptr >= k_idx) ? (wptr - k_idx) : (wptr + tap_num - k_idx);

endmodule

// File: rtl/fir_sched.sv
// fir_sched: sample-by-sample FIR scheduler over a tap BRAM and a data ring BRAM.
// Ports:
//   aclk, areset            clock, async active-high reset
//   ap_start/ap_idle/ap_done  run control
//   tap_num, data_num       run size, latched on an accepted start
//   tap_A/EN/Do             tap RAM read port (byte address)
//   data_A/EN/WE/Di/Do      data ring RAM port (byte address)
//   ss_*                    input sample stream
//   sm_*                    output result stream
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a legal ap_start
// ST_INIT    | zeroing ring words 0..tap_num-1, one per cycle
// ST_WAIT_IN | ss_tready high; a handshake writes the sample at wptr
// ST_CALC    | tap_num reads plus one drain cycle accumulating products
// ST_OUT     | presenting acc on sm_*; held until sm_tready
module fir_sched
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH  = 32,
  parameter int pADDR_WIDTH  = 12,
  parameter int MAX_TAP_NUM  = 32,
  parameter int MAX_DATA_NUM = 1024
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           ap_start,
  output logic                           ap_idle,
  output logic                           ap_done,
  input  logic [$clog2(MAX_TAP_NUM):0]   tap_num,
  input  logic [$clog2(MAX_DATA_NUM):0]  data_num,
  output logic [pADDR_WIDTH-1:0]         tap_A,
  output logic                           tap_EN,
  input  logic [pDATA_WIDTH-1:0]         tap_Do,
  output logic [pADDR_WIDTH-1:0]         data_A,
  output logic                           data_EN,
  output logic [pDATA_WIDTH/8-1:0]       data_WE,
  output logic [pDATA_WIDTH-1:0]         data_Di,
  input  logic [pDATA_WIDTH-1:0]         data_Do,
  input  logic                           ss_tvalid,
  input  logic [pDATA_WIDTH-1:0]         ss_tdata,
  input  logic                           ss_tlast,
  output logic                           ss_tready,
  output logic                           sm_tvalid,
  output logic [pDATA_WIDTH-1:0]         sm_tdata,
  output logic                           sm_tlast,
  input  logic                           sm_tready
);

  localparam int TW = $clog2(MAX_TAP_NUM) + 1;
  localparam int DW = $clog2(MAX_DATA_NUM) + 1;

  fir_state_t state, state_nxt;

  logic [TW-1:0]          tap_num_q;
  logic [DW-1:0]          data_num_q;
  logic                   tlast_q;
  logic [pDATA_WIDTH-1:0] acc;
  logic [pDATA_WIDTH-1:0] prod;

  logic [TW-1:0] k_idx, data_idx, wptr;
  logic [DW-1:0] smp_cnt;

  logic start_ok, run_clr, ss_hs, sm_hs;
  logic init_last, calc_rd, calc_last, mac_en, is_last;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [TW-1:0] idx);
    return pADDR_WIDTH'(idx) << ADDR_SHIFT;
  endfunction

  assign start_ok  = ap_start
                   && (tap_num != '0)  && (tap_num <= TW'(MAX_TAP_NUM))
                   && (data_num != '0) && (data_num <= DW'(MAX_DATA_NUM));
  assign run_clr   = (state == ST_IDLE) && start_ok;
  assign ss_hs     = (state == ST_WAIT_IN) && ss_tvalid;
  assign sm_hs     = (state == ST_OUT) && sm_tready;
  assign init_last = (state == ST_INIT) && (k_idx == tap_num_q - 1'b1);
  assign calc_rd   = (state == ST_CALC) && (k_idx != tap_num_q);
  assign calc_last = (state == ST_CALC) && (k_idx == tap_num_q);
  // Read data arrives one cycle after the read, so CALC step 0 has nothing to add.
  assign mac_en    = (state == ST_CALC) && (k_idx != '0);
  // Counters are frozen in OUT, so this stays stable while the result is held.
  assign is_last   = tlast_q || (smp_cnt == data_num_q - 1'b1);

  // Low bits of a signed product equal the truncated two's-complement result.
  assign prod = $signed(tap_Do) * $signed(data_Do);

  fir_addr_gen #(
    .TW (TW),
    .DW (DW)
  ) u_addr_gen (
    .aclk     (aclk),
    .areset   (areset),
    .tap_num  (tap_num_q),
    .run_clr  (run_clr),
    .k_clr    (init_last || ss_hs),
    .k_inc    ((state == ST_INIT) || (state == ST_CALC)),
    .wptr_adv (calc_last),
    .smp_inc  (sm_hs && !is_last),
    .k_idx    (k_idx),
    .data_idx (data_idx),
    .wptr     (wptr),
    .smp_cnt  (smp_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_ok)  state_nxt = ST_INIT;
      ST_INIT:    if (init_last) state_nxt = ST_WAIT_IN;
      ST_WAIT_IN: if (ss_tvalid) state_nxt = ST_CALC;
      ST_CALC:    if (calc_last) state_nxt = ST_OUT;
      ST_OUT:     if (sm_tready) state_nxt = is_last ? ST_IDLE : ST_WAIT_IN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      tap_num_q  <= '0;
      data_num_q <= '0;
      tlast_q    <= 1'b0;
      acc        <= '0;
      ap_done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ap_done <= sm_hs && is_last;
      if (run_clr) begin
        tap_num_q  <= tap_num;
        data_num_q <= data_num;
        tlast_q    <= 1'b0;
      end
      if (ss_hs) begin
        tlast_q <= ss_tlast;
        acc     <= '0;
      end else if (mac_en) begin
        acc <= acc + prod;
      end
    end
  end

  assign ap_idle = (state == ST_IDLE);

  always_comb begin
    tap_A     = '0;
    tap_EN    = 1'b0;
    data_A    = '0;
    data_EN   = 1'b0;
    data_WE   = '0;
    data_Di   = '0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    case (state)
      ST_INIT: begin
        data_EN = 1'b1;
        data_WE = '1;
        data_A  = word_addr(k_idx);
      end
      ST_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = '1;
          data_A  = word_addr(wptr);
          data_Di = ss_tdata;
        end
      end
      ST_CALC: begin
        if (calc_rd) begin
          tap_EN  = 1'b1;
          tap_A   = word_addr(k_idx);
          data_EN = 1'b1;
          data_A  = word_addr(data_idx);
        end
      end
      ST_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = acc;
        sm_tlast  = is_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: randomized self-checking bench for fir_sched with BRAM models
// and a direct-form FIR reference (y[n] = sum tap[k]*x[n-k], zero history).
module tb_fir_sched;

  localparam int W  = 32;
  localparam int AW = 12;
  localparam int TW = 6;
  localparam int DW = 11;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ap_start;
  logic          ap_idle, ap_done;
  logic [TW-1:0] tap_num;
  logic [DW-1:0] data_num;
  logic [AW-1:0] tap_A, data_A;
  logic          tap_EN, data_EN;
  logic [W/8-1:0] data_WE;
  logic [W-1:0]  tap_Do, data_Di, data_Do;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic [W-1:0]  ss_tdata;
  logic          sm_tvalid, sm_tlast, sm_tready;
  logic [W-1:0]  sm_tdata;

  always #5 aclk = ~aclk;

  fir_sched dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .tap_num(tap_num), .data_num(data_num),
    .tap_A(tap_A), .tap_EN(tap_EN), .tap_Do(tap_Do),
    .data_A(data_A), .data_EN(data_EN), .data_WE(data_WE),
    .data_Di(data_Di), .data_Do(data_Do),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready)
  );

  logic [W-1:0] tap_ram  [0:1023];
  logic [W-1:0] data_ram [0:1023];
  logic         scramble;

  always @(posedge aclk) begin
    if (scramble)
      for (int j = 0; j < 64; j++) data_ram[j] <= $urandom;
    if (tap_EN) tap_Do <= tap_ram[tap_A[AW-1:2]];
    if (data_EN) begin
      data_Do <= data_ram[data_A[AW-1:2]];
      for (int b = 0; b < W/8; b++)
        if (data_WE[b]) data_ram[data_A[AW-1:2]][8*b +: 8] <= data_Di[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] taps [32];
  logic [W-1:0] xin  [64];
  logic [W-1:0] exp_d [$];
  logic [W-1:0] got_d [$];
  bit           got_l [$];
  logic [W-1:0] ref_d [$];

  function automatic void model(input int tn, input int nres);
    logic [W-1:0] a;
    exp_d.delete();
    for (int n = 0; n < nres; n++) begin
      a = '0;
      for (int k = 0; k < tn; k++)
        if (n - k >= 0) a = a + taps[k] * xin[n-k];
      exp_d.push_back(a);
    end
  endfunction

  task automatic do_scramble();
    scramble = 1'b1;
    @(posedge aclk); #1;
    scramble = 1'b0;
  endtask

  // mode 0: random sm_tready; mode 1: hold sm_tready low 5 cycles per result.
  // abort_at > 0: return mid-CALC after that many samples, skipping end checks.
  task automatic do_run(input int tn, input int dn, input int tlast_at,
                        input int mode, input int abort_at);
    int nres, i, cyc, done_cnt, done_cyc, last_hs_cyc, hold, abort_cnt;
    bit finished, prev_stall, prev_l;
    logic [W-1:0] prev_d;
    nres = (tlast_at >= 0 && tlast_at < dn) ? tlast_at + 1 : dn;
    for (int k = 0; k < tn; k++) tap_ram[k] = taps[k];
    model(tn, nres);
    got_d.delete();
    got_l.delete();
    i = 0; cyc = 0; done_cnt = 0; done_cyc = -10; last_hs_cyc = -20;
    hold = 0; abort_cnt = 0; finished = 0; prev_stall = 0; prev_l = 0; prev_d = '0;

    ap_start = 1'b1;
    tap_num  = TW'(tn);
    data_num = DW'(dn);
    @(posedge aclk); #1;
    ap_start = 1'b0;
    chk("start_taken", ap_idle, 0);

    while (!finished && cyc < 4000) begin
      ss_tvalid = (i < nres) && ($urandom_range(3) != 0);
      ss_tdata  = (i < 64) ? xin[i] : '0;
      ss_tlast  = (i == tlast_at);
      if (mode == 1) begin
        if (!sm_tvalid) begin
          hold = 0;
          sm_tready = 1'b0;
        end else if (hold < 5) begin
          hold++;
          sm_tready = 1'b0;
        end else begin
          sm_tready = 1'b1;
        end
      end else begin
        sm_tready = ($urandom_range(2) != 0);
      end
      ap_start = (got_d.size() < nres) && ($urandom_range(7) == 0);
      tap_num  = TW'($urandom);
      data_num = DW'($urandom);

      @(negedge aclk);
      if (prev_stall) begin
        chk("hold_valid", sm_tvalid, 1);
        chk("hold_data", sm_tdata, prev_d);
        chk("hold_last", sm_tlast, prev_l);
      end
      prev_stall = sm_tvalid && !sm_tready;
      prev_d = sm_tdata;
      prev_l = sm_tlast;
      if (mode == 1 && sm_tvalid) chk("ss_ready_in_out", ss_tready, 0);
      if (ss_tvalid && ss_tready) i++;
      if (sm_tvalid && sm_tready) begin
        got_d.push_back(sm_tdata);
        got_l.push_back(sm_tlast);
        last_hs_cyc = cyc;
        if (mode == 1) chk("release_after_5", hold, 5);
      end
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort_at > 0 && i >= abort_at) begin
        abort_cnt++;
        if (abort_cnt == 3) begin
          chk("abort_in_calc", tap_EN, 1);
          return;
        end
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) finished = 1;
      @(posedge aclk); #1;
      cyc++;
    end
    ss_tvalid = 1'b0;
    sm_tready = 1'b0;
    ap_start  = 1'b0;

    chk("run_finished", finished, 1);
    chk("n_results", got_d.size(), nres);
    chk("inputs_used", i, nres);
    for (int j = 0; j < nres && j < got_d.size(); j++) begin
      chk($sformatf("result[%0d]", j), got_d[j], exp_d[j]);
      chk($sformatf("tlast[%0d]", j), got_l[j], (j == nres - 1));
    end
    chk("done_pulses", done_cnt, 1);
    chk("done_timing", done_cyc, last_hs_cyc + 1);
    chk("idle_after", ap_idle, 1);
    chk("ss_ready_after", ss_tready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] lit [4];
    logic [W-1:0] wrap_exp;
    int bad_tn [4];
    int bad_dn [4];
    bit seen_bad;
    int tn, dn, tl;

    areset = 1'b1; ap_start = 1'b0; tap_num = '0; data_num = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
    scramble = 1'b0;

    repeat (2) @(posedge aclk);
    #1;
    ap_start = 1'b1; tap_num = 6'd3; data_num = 11'd4;
    @(posedge aclk); #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ss_ready", ss_tready, 0);
    chk("rst_sm_valid", sm_tvalid, 0);
    chk("rst_sm_data", sm_tdata, 0);
    chk("rst_sm_last", sm_tlast, 0);
    chk("rst_tap_en", tap_EN, 0);
    chk("rst_data_en", data_EN, 0);
    chk("rst_data_we", data_WE, 0);
    chk("rst_addr", {tap_A, data_A}, 0);
    ap_start = 1'b0;
    areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    chk("no_restart", ap_idle, 1);

    // Small worked example
    taps[0] = 1; taps[1] = 2; taps[2] = 3;
    xin[0] = 1; xin[1] = 2; xin[2] = 3; xin[3] = 4;
    lit = '{32'd1, 32'd4, 32'd10, 32'd16};
    do_scramble();
    do_run(3, 4, -1, 0, 0);
    for (int j = 0; j < 4 && j < got_d.size(); j++)
      chk($sformatf("example[%0d]", j), got_d[j], lit[j]);

    // Illegal starts
    bad_tn = '{0, 5, 33, 5};
    bad_dn = '{5, 0, 5, 1025};
    for (int b = 0; b < 4; b++) begin
      seen_bad = 0;
      ap_start = 1'b1;
      tap_num  = TW'(bad_tn[b]);
      data_num = DW'(bad_dn[b]);
      @(posedge aclk); #1;
      ap_start = 1'b0;
      repeat (6) begin
        if (!ap_idle || ss_tready || ap_done) seen_bad = 1;
        @(posedge aclk); #1;
      end
      chk($sformatf("bad_start[%0d]", b), seen_bad, 0);
    end

    // Output back-pressure
    for (int k = 0; k < 4; k++) taps[k] = $urandom_range(100);
    for (int n = 0; n < 3; n++) xin[n] = $urandom;
    do_scramble();
    do_run(4, 3, -1, 1, 0);

    // Early ss_tlast on the 3rd sample
    for (int k = 0; k < 5; k++) taps[k] = $urandom;
    for (int n = 0; n < 8; n++) xin[n] = $urandom;
    do_scramble();
    do_run(5, 8, 2, 0, 0);
    chk("early_last_count", got_d.size(), 3);

    // Reset mid-run, then identical rerun
    for (int k = 0; k < 4; k++) taps[k] = $urandom;
    for (int n = 0; n < 5; n++) xin[n] = $urandom_range(1000);
    do_scramble();
    do_run(4, 5, -1, 0, 0);
    ref_d = got_d;
    do_run(4, 5, -1, 0, 2);
    @(posedge aclk); #1;
    ss_tvalid = 1'b0; sm_tready = 1'b0; ap_start = 1'b0;
    areset = 1'b1;
    #1;
    chk("mid_rst_idle", ap_idle, 1);
    chk("mid_rst_tap_en", tap_EN, 0);
    chk("mid_rst_data_en", data_EN, 0);
    chk("mid_rst_sm_valid", sm_tvalid, 0);
    chk("mid_rst_sm_data", sm_tdata, 0);
    chk("mid_rst_ss_ready", ss_tready, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    chk("post_rst_idle", ap_idle, 1);
    do_run(4, 5, -1, 0, 0);
    chk("rerun_count", got_d.size(), ref_d.size());
    for (int j = 0; j < ref_d.size() && j < got_d.size(); j++)
      chk($sformatf("rerun[%0d]", j), got_d[j], ref_d[j]);

    // Product wrap
    taps[0] = 32'h7FFF_FFFF;
    xin[0]  = 32'd2;
    wrap_exp = 32'hFFFF_FFFE;
    do_scramble();
    do_run(1, 1, -1, 0, 0);
    if (got_d.size() > 0) chk("wrap_result", got_d[0], wrap_exp);
    else chk("wrap_present", got_d.size(), 1);

    // Randomized runs, including the full tap count
    for (int r = 0; r < 8; r++) begin
      tn = (r == 7) ? 32 : $urandom_range(8, 1);
      dn = (r == 7) ? 3 : $urandom_range(16, 1);
      tl = ($urandom_range(3) == 0) ? $urandom_range(dn - 1, 0) : -1;
      for (int k = 0; k < tn; k++) taps[k] = $urandom;
      for (int n = 0; n < dn; n++) xin[n] = $urandom;
      do_scramble();
      do_run(tn, dn, tl, $urandom_range(1), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
